// File: rtl/dsp_mac_sequencer.sv
// Dot-product sequencer for a pipelined DSP MAC slice (MREG=1, PREG=1,
// OPMODEREG=1). Streams operand pairs into the slice, accumulates in P,
// waits for the pipeline to drain and presents the result.
//
// Handshakes: a transfer happens on every rising edge where valid and
// ready are both 1. The producer may hold valid low at any time. The
// consumer may hold ready low for as long as it likes, and the result
// stays stable meanwhile.
module dsp_mac_sequencer #(
  parameter int DATA_W = 18,
  parameter int P_W    = 48,
  parameter int LEN_W  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [LEN_W-1:0]  i_cfg_len,
  input  logic              i_cfg_sub,
  output logic              o_busy,
  output logic              o_err_len,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DATA_W-1:0] i_in_a,
  input  logic [DATA_W-1:0] i_in_b,
  output logic [DATA_W-1:0] o_dsp_a,
  output logic [DATA_W-1:0] o_dsp_b,
  output logic [7:0]        o_dsp_opmode,
  output logic              o_dsp_cem,
  output logic              o_dsp_cep,
  input  logic [P_W-1:0]    i_dsp_p,
  output logic              o_res_valid,
  input  logic              i_res_ready,
  output logic [P_W-1:0]    o_res_data,
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_cnt;
  logic              r_sub;
  logic              r_first;
  logic [1:0]        r_drain;
  logic              r_err_len;
  logic [DATA_W-1:0] r_dsp_a;
  logic [DATA_W-1:0] r_dsp_b;
  logic [7:0]        r_dsp_opmode;
  logic              r_dsp_cem;
  logic              r_dsp_cep;
  logic              r_res_valid;
  logic [P_W-1:0]    r_res_data;

  logic w_xfer;
  logic w_last;
  logic w_start_ok;
  logic w_start_err;
  logic w_drain_end;
  logic w_res_hs;

  assign w_xfer      = (r_state == S_LOAD) && i_in_valid;
  // r_cnt never exceeds r_len-1 while loading, so the increment cannot wrap
  assign w_last      = w_xfer && ((r_cnt + LEN_W'(1)) == r_len);
  assign w_start_ok  = (r_state == S_IDLE) && i_start && (i_cfg_len != '0);
  assign w_start_err = (r_state == S_IDLE) && i_start && (i_cfg_len == '0);
  // Third DRAIN cycle: P already holds the last product
  assign w_drain_end = (r_state == S_DRAIN) && (r_drain == 2'd2);
  assign w_res_hs    = (r_state == S_DONE) && i_res_ready;

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok)  w_state_next = S_LOAD;
      S_LOAD:  if (w_last)      w_state_next = S_DRAIN;
      S_DRAIN: if (w_drain_end) w_state_next = S_DONE;
      S_DONE:  if (w_res_hs)    w_state_next = S_IDLE;
      default:                  w_state_next = S_IDLE;
    endcase
  end

  // State register, configuration latch, DSP operand/control pipeline, result
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_len        <= '0;
      r_cnt        <= '0;
      r_sub        <= 1'b0;
      r_first      <= 1'b0;
      r_drain      <= 2'd0;
      r_err_len    <= 1'b0;
      r_dsp_a      <= '0;
      r_dsp_b      <= '0;
      r_dsp_opmode <= 8'd0;
      r_dsp_cem    <= 1'b0;
      r_dsp_cep    <= 1'b0;
      r_res_valid  <= 1'b0;
      r_res_data   <= '0;
    end else begin
      r_state   <= w_state_next;
      r_err_len <= w_start_err;
      r_dsp_cem <= w_xfer;
      r_dsp_cep <= r_dsp_cem;
      if (w_start_ok) begin
        r_len   <= i_cfg_len;
        r_sub   <= i_cfg_sub;
        r_cnt   <= '0;
        r_first <= 1'b1;
      end
      if (w_xfer) begin
        r_dsp_a      <= i_in_a;
        r_dsp_b      <= i_in_b;
        // bit7 subtract, bit3 Z=P after the first pair, bits1:0 X=M
        r_dsp_opmode <= {r_sub, 3'b000, ~r_first, 3'b001};
        r_cnt        <= r_cnt + LEN_W'(1);
        r_first      <= 1'b0;
      end
      if (w_last) begin
        r_drain <= 2'd0;
      end else if (r_state == S_DRAIN) begin
        r_drain <= r_drain + 2'd1;
      end
      if (w_drain_end) begin
        r_res_data  <= i_dsp_p;
        r_res_valid <= 1'b1;
      end else if (w_res_hs) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign o_busy       = (r_state != S_IDLE);
  assign o_in_ready   = (r_state == S_LOAD);
  assign o_err_len    = r_err_len;
  assign o_dsp_a      = r_dsp_a;
  assign o_dsp_b      = r_dsp_b;
  assign o_dsp_opmode = r_dsp_opmode;
  assign o_dsp_cem    = r_dsp_cem;
  assign o_dsp_cep    = r_dsp_cep;
  assign o_res_valid  = r_res_valid;
  assign o_res_data   = r_res_data;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer: contains a behavioural model of the DSP slice
// feeding i_dsp_p, an event-level model of expected outputs and a per-cycle
// compare process, plus directed runs with literal expected results.
module tb_dsp_mac_sequencer;
  localparam int DATA_W = 18;
  localparam int P_W    = 48;
  localparam int LEN_W  = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              start = 1'b0;
  logic [LEN_W-1:0]  cfg_len = '0;
  logic              cfg_sub = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_a = '0;
  logic [DATA_W-1:0] in_b = '0;
  logic              res_ready = 1'b0;
  logic              busy, err_len, in_ready, dsp_cem, dsp_cep, res_valid;
  logic [DATA_W-1:0] dsp_a, dsp_b;
  logic [7:0]        dsp_opmode;
  logic [P_W-1:0]    res_data;
  logic [1:0]        dbg_state;
  logic [P_W-1:0]    dsp_p;

  dsp_mac_sequencer #(.DATA_W(DATA_W), .P_W(P_W), .LEN_W(LEN_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_cfg_len(cfg_len),
    .i_cfg_sub(cfg_sub), .o_busy(busy), .o_err_len(err_len),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_a(in_a), .i_in_b(in_b),
    .o_dsp_a(dsp_a), .o_dsp_b(dsp_b), .o_dsp_opmode(dsp_opmode),
    .o_dsp_cem(dsp_cem), .o_dsp_cep(dsp_cep), .i_dsp_p(dsp_p),
    .o_res_valid(res_valid), .i_res_ready(res_ready), .o_res_data(res_data),
    .o_dbg_state(dbg_state)
  );

  // ---------------- DSP slice model (M, OPMODE and P registers) ----------------
  logic [P_W-1:0] dm   = 48'h0000_1111_2222;
  logic [7:0]     dopm = 8'h00;
  logic [P_W-1:0] dp   = 48'hABCD_EF01_2345; // stale contents on purpose
  always @(posedge clk) begin
    if (dsp_cem) dm <= {30'd0, dsp_a} * {30'd0, dsp_b};
    dopm <= dsp_opmode;
    if (dsp_cep)
      dp <= dopm[7] ? (((dopm[3:2] == 2'b10) ? dp : 48'd0) - ((dopm[1:0] == 2'b01) ? dm : 48'd0))
                    : (((dopm[3:2] == 2'b10) ? dp : 48'd0) + ((dopm[1:0] == 2'b01) ? dm : 48'd0));
  end
  assign dsp_p = dp;

  // ---------------- scoreboard / counters ----------------
  int checks = 0;
  int failures = 0;
  logic [P_W-1:0] exp_q[$];
  logic [DATA_W-1:0] qa[$];
  logic [DATA_W-1:0] qb[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- event-level expected-output model ----------------
  // Driver announces each transfer (and whether it is the last); the model
  // derives what the outputs must look like after each edge.
  logic           drv_xfer = 1'b0;
  logic           drv_last = 1'b0;
  logic           drv_err  = 1'b0;
  logic [7:0]     drv_op   = 8'h00;
  logic           m_cem = 1'b0, m_cep = 1'b0, m_err = 1'b0, m_res_valid = 1'b0;
  logic [DATA_W-1:0] m_a = '0, m_b = '0;
  logic [7:0]     m_op = 8'h00;
  logic [P_W-1:0] m_res = '0;
  int             m_wait = 0; // edges left until the result must appear

  always @(posedge clk) begin
    if (rst) begin
      m_cem <= 1'b0; m_cep <= 1'b0; m_err <= 1'b0; m_res_valid <= 1'b0;
      m_a <= '0; m_b <= '0; m_op <= 8'h00; m_res <= '0; m_wait <= 0;
    end else begin
      m_cem <= drv_xfer;
      m_cep <= m_cem;
      m_err <= drv_err;
      if (drv_xfer) begin
        m_a <= in_a; m_b <= in_b; m_op <= drv_op;
      end
      if (drv_xfer && drv_last) m_wait <= 3;
      else if (m_wait != 0)     m_wait <= m_wait - 1;
      if (m_wait == 1) begin
        m_res_valid <= 1'b1;
        if (exp_q.size() > 0) m_res <= exp_q.pop_front();
      end else if (m_res_valid && res_ready) begin
        m_res_valid <= 1'b0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (!rst) begin
      chk("dsp_cem", 64'(dsp_cem), 64'(m_cem));
      chk("dsp_cep", 64'(dsp_cep), 64'(m_cep));
      chk("dsp_a", 64'(dsp_a), 64'(m_a));
      chk("dsp_b", 64'(dsp_b), 64'(m_b));
      chk("dsp_opmode", 64'(dsp_opmode), 64'(m_op));
      chk("err_len", 64'(err_len), 64'(m_err));
      chk("res_valid", 64'(res_valid), 64'(m_res_valid));
      if (m_res_valid) chk("res_data", 64'(res_data), 64'(m_res));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input int len, input logic sub);
    start = 1'b1; cfg_len = LEN_W'(len); cfg_sub = sub;
    drv_err = (len == 0);
    tick();
    start = 1'b0; drv_err = 1'b0;
  endtask

  task automatic send(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                      input logic first, input logic last, input logic sub);
    chk("in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_a = a; in_b = b;
    drv_xfer = 1'b1; drv_last = last;
    drv_op = sub ? (first ? 8'h81 : 8'h89) : (first ? 8'h01 : 8'h09);
    tick();
    in_valid = 1'b0; drv_xfer = 1'b0; drv_last = 1'b0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err_len", 64'(err_len), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_cem_cep", {62'd0, dsp_cem, dsp_cep}, 64'd0);
    chk("rst_dsp_ab", {28'd0, dsp_a, dsp_b}, 64'd0);
    chk("rst_opmode", 64'(dsp_opmode), 64'd0);
    chk("rst_res_data", 64'(res_data), 64'd0);
  endtask

  // Full operation using operands in qa/qb; lit is the hand-computed result.
  task automatic run_op(input int len, input logic sub, input int gap, input int rdelay,
                        input logic [P_W-1:0] lit, input logic poke_start);
    logic [63:0] s;
    int n;
    s = 64'd0;
    for (int i = 0; i < qa.size(); i++) s += 64'(qa[i]) * 64'(qb[i]);
    if (sub) s = -s;
    chk("model_pin", 64'(s[P_W-1:0]), 64'(lit));
    exp_q.push_back(s[P_W-1:0]);
    start_op(len, sub);
    chk("busy_load", 64'(busy), 64'd1);
    for (int k = 0; k < len; k++) begin
      if (poke_start && k == 1) begin
        start = 1'b1; cfg_len = '0; cfg_sub = ~sub;
      end
      send(qa[k], qb[k], k == 0, k == len - 1, sub);
      start = 1'b0;
      if (k != len - 1)
        for (int g = 0; g < gap; g++) tick();
    end
    n = 0;
    while (!res_valid && n < 20) begin
      tick();
      n++;
    end
    if (!res_valid) begin
      chk("res_timeout", 64'd0, 64'd1);
      return;
    end
    chk("res_latency", 64'(n), 64'd3);
    chk("res_literal", 64'(res_data), 64'(lit));
    for (int d = 0; d < rdelay; d++) tick();
    chk("res_hold", 64'(res_data), 64'(lit));
    // handshake with a simultaneous start that must be ignored
    res_ready = 1'b1; start = 1'b1; cfg_len = LEN_W'(3); cfg_sub = 1'b0;
    tick();
    res_ready = 1'b0; start = 1'b0;
    chk("idle_after_hs", {62'd0, busy, in_ready}, 64'd0);
    qa.delete(); qb.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    repeat (3) tick();
    check_reset_outputs();
    rst = 1'b0;
    tick();

    qa = '{1, 2, 3, 4}; qb = '{5, 6, 7, 8};
    run_op(4, 1'b0, 0, 0, 48'd70, 1'b0);

    qa = '{3, 4}; qb = '{2, 5};
    run_op(2, 1'b1, 0, 0, 48'hFFFF_FFFF_FFE6, 1'b0);

    qa = '{18'h3FFFF}; qb = '{18'h3FFFF};
    run_op(1, 1'b0, 0, 0, 48'h000F_FFF8_0001, 1'b0);

    qa = '{1, 2, 3, 4}; qb = '{5, 6, 7, 8};
    run_op(4, 1'b0, 2, 0, 48'd70, 1'b0);

    // zero length: one-cycle error pulse, never busy
    start_op(0, 1'b0);
    chk("err_pulse", {62'd0, err_len, busy}, 64'd2);
    tick();
    chk("err_gone", {62'd0, err_len, busy}, 64'd0);

    // start (with len 0, sub flipped) while loading has no effect
    qa = '{1, 2, 3, 4}; qb = '{5, 6, 7, 8};
    run_op(4, 1'b0, 0, 0, 48'd70, 1'b1);

    // consumer stalls the result for 5 cycles
    qa = '{1, 2, 3, 4}; qb = '{5, 6, 7, 8};
    run_op(4, 1'b0, 0, 5, 48'd70, 1'b0);

    // reset after 2 of 4 transfers
    start_op(4, 1'b0);
    send(9, 9, 1'b1, 1'b0, 1'b0);
    send(7, 7, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs();
    repeat (6) tick();
    qa = '{1, 1}; qb = '{2, 3};
    run_op(2, 1'b0, 0, 0, 48'd5, 1'b0);

    // maximum length without counter wrap: sum(k*2, k=1..255)
    for (int k = 1; k <= 255; k++) begin
      qa.push_back(DATA_W'(k));
      qb.push_back(DATA_W'(2));
    end
    run_op(255, 1'b0, 0, 0, 48'd65280, 1'b0);

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/dsp_mac_sequencer.md
DSP_MAC_SEQUENCER -- requirements
Module: dsp_mac_sequencer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 18: width of the A/B operands and of dsp_a/dsp_b.
REQ-002 The block SHALL have parameter P_W, default 48: width of the DSP P bus and of res_data.
REQ-003 The block SHALL have parameter LEN_W, default 8: width of the vector-length field.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 start  in  1  single-cycle request to begin a dot product.
REQ-008 cfg_len  in  LEN_W  number of element pairs, sampled with start.
REQ-009 cfg_sub  in  1  sampled with start; 1 gives result = -sum(a*b).
REQ-010 busy  out  1  high whenever state is not IDLE.
REQ-011 err_len  out  1  one-cycle pulse when start arrives with cfg_len = 0.
REQ-012 in_valid / in_ready  in / out  1 / 1  operand-stream handshake.
REQ-013 in_a, in_b  in  DATA_W  unsigned operand pair.
REQ-014 dsp_a, dsp_b  out  DATA_W  registered operands to the DSP A/B ports.
REQ-015 dsp_opmode  out  8  registered value to the DSP OPMODE port.
REQ-016 dsp_cem, dsp_cep  out  1  registered M and P clock enables to the DSP.
REQ-017 dsp_p  in  P_W  DSP P output.
REQ-018 res_valid / res_ready  out / in  1 / 1  result handshake.
REQ-019 res_data  out  P_W  dot-product result.

Function
REQ-020 The block SHALL sequence a DSP slice built with A0REG=A1REG=B0REG=B1REG=0, MREG=1, OPMODEREG=1, PREG=1, CARRYINSEL=OPMODE5 and B_INPUT=DIRECT.
REQ-021 The block SHALL implement states IDLE, LOAD, DRAIN and DONE.
REQ-022 In IDLE, start with cfg_len != 0 SHALL latch cfg_len and cfg_sub and go to LOAD.
REQ-023 In IDLE, start with cfg_len = 0 SHALL pulse err_len and keep the state in IDLE.
REQ-024 start outside IDLE SHALL be ignored.
REQ-025 in_ready SHALL be 1 exactly while in LOAD.
REQ-026 A transfer SHALL occur on each edge where in_valid and in_ready are both 1.
REQ-027 At the edge of transfer k, dsp_a/dsp_b SHALL load in_a/in_b and dsp_cem SHALL be set to 1.
REQ-028 On edges without a transfer, dsp_cem SHALL be 0 and dsp_a/dsp_b SHALL hold their values.
REQ-029 dsp_cep SHALL equal dsp_cem delayed by one clock.
REQ-030 dsp_opmode for the first transfer SHALL be 8'b0000_0001 (X=M, Z=0, add, CIN=0, no pre-add).
REQ-031 dsp_opmode for each later transfer SHALL be 8'b0000_1001 (Z=P) when cfg_sub=0.
REQ-032 dsp_opmode SHALL be 8'b1000_0001 for the first transfer and 8'b1000_1001 for each later transfer when cfg_sub=1.
REQ-033 dsp_opmode SHALL hold its value between transfers.
REQ-034 The first-transfer flag SHALL be set on entry to LOAD and cleared after the first transfer.
REQ-035 An element counter SHALL count transfers; the transfer that makes count = cfg_len SHALL move the state to DRAIN at that edge.
REQ-036 DRAIN SHALL last exactly 3 cycles.
REQ-037 For a last transfer at edge eL: P is captured by the DSP at eL+2, and res_data SHALL load dsp_p and res_valid SHALL go to 1 at eL+3, entering DONE.
REQ-038 In DONE, res_valid and res_data SHALL hold until res_ready=1; at that edge res_valid SHALL go to 0 and the state to IDLE.
REQ-039 A start in the same cycle as the result handshake SHALL be ignored.
REQ-040 Gaps with in_valid=0 SHALL NOT change the result.
REQ-041 Arithmetic SHALL be unsigned 18x18 into 36 bits, zero-extended, then accumulated modulo 2^P_W; there is no saturation or overflow flag.
REQ-042 The element counter SHALL be LEN_W wide; the maximum length 2^LEN_W-1 SHALL complete without wrap.

Reset
REQ-043 On rst=1 at a clock edge, the state SHALL become IDLE.
REQ-044 On reset, busy, err_len, in_ready, res_valid, dsp_cem and dsp_cep SHALL be 0.
REQ-045 On reset, dsp_a, dsp_b, dsp_opmode, res_data, the counter and the latched configuration SHALL be 0.
REQ-046 Reset mid-operation SHALL abandon the operation with no res_valid.
REQ-047 The block SHALL NOT drive the DSP reset pins; the first-transfer opmode Z=0 makes stale P contents irrelevant.

Verification
REQ-048 len=4, cfg_sub=0, a={1,2,3,4}, b={5,6,7,8}, back-to-back -> res_data=70, res_valid at eL+3.
REQ-049 len=2, cfg_sub=1, a={3,4}, b={2,5} -> res_data=48'hFFFF_FFFF_FFE6 (-26).
REQ-050 len=1, a=b=18'h3FFFF -> res_data=48'h000F_FFF8_0001.
REQ-051 Test 048 repeated with in_valid low for 2 cycles between each pair -> dsp_cem=0 during the gaps and res_data=70.
REQ-052 cfg_len=0 -> err_len high for exactly 1 cycle and busy stays 0; start during LOAD -> no effect.
REQ-053 rst after 2 of 4 transfers -> all outputs return to reset values with no res_valid; next op len=2, a={1,1}, b={2,3} -> 5.
REQ-054 res_ready held low 5 cycles -> res_valid and res_data stay stable; the result is accepted on the first edge with res_ready=1.
